// File: rtl/clear_req_encoder.sv
// clear_req_encoder: buffers multi-hot clear requests in a pending vector and
// drains them one register address per accepted cycle over valid/ready.
module clear_req_encoder #(
    parameter int N       = 32,
    parameter int AW      = $clog2(N),
    parameter bit RR_MODE = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_vec,
    input  logic          flush,
    input  logic          ready,
    output logic [AW-1:0] addr,
    output logic          clear_en,
    output logic [AW:0]   pend_cnt,
    output logic          dup_hit
);
    logic [N-1:0]  pending;
    logic [N-1:0]  pend_next;
    logic [N-1:0]  acc_oh;
    logic [AW-1:0] ptr;
    logic [AW-1:0] held_idx;
    logic [AW-1:0] sel;
    logic          lock;
    logic          accept;

    // Scan from ptr with wrap; the last hit in a descending scan is the nearest.
    // In fixed-priority mode ptr stays 0, so this degenerates to lowest index.
    always_comb begin
        sel = '0;
        for (int i = N - 1; i >= 0; i--) begin
            int j;
            j = (int'(ptr) + i >= N) ? int'(ptr) + i - N : int'(ptr) + i;
            if (pending[j]) sel = AW'(j);
        end
    end

    assign clear_en  = |pending;
    assign addr      = lock ? held_idx : (clear_en ? sel : '1);
    assign accept    = clear_en & ready;
    assign acc_oh    = accept ? (N'(1) << addr) : '0;
    assign pend_next = flush ? '0 : ((pending & ~acc_oh) | req_vec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            ptr      <= '0;
            lock     <= 1'b0;
            held_idx <= '0;
            pend_cnt <= '0;
            dup_hit  <= 1'b0;
        end else begin
            pending  <= pend_next;
            pend_cnt <= (AW+1)'($countones(pend_next));
            dup_hit  <= !flush && |(req_vec & pending & ~acc_oh);
            lock     <= !flush && clear_en && !ready;
            if (clear_en && !ready) held_idx <= addr;
            if (flush) ptr <= '0;
            else if (RR_MODE && accept) ptr <= (addr == AW'(N - 1)) ? '0 : addr + 1'b1;
        end
    end
endmodule

// File: tb/tb_clear_req_encoder.sv
// tb_clear_req_encoder: table-driven check of fixed-priority and round-robin
// instances, with a scoreboard queue of expected post-edge outputs.
module tb_clear_req_encoder;
    typedef struct {
        bit          rr;
        logic [31:0] req;
        logic        flush;
        logic        ready;
        logic        ce;
        logic [4:0]  addr;
        logic [5:0]  cnt;
        logic        dup;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] f_req = 32'hFFFF_FFFF, r_req = '0;
    logic        f_flush = 1'b0, r_flush = 1'b0, f_ready = 1'b0, r_ready = 1'b0;
    logic [4:0]  f_addr, r_addr;
    logic        f_ce, r_ce, f_dup, r_dup;
    logic [5:0]  f_cnt, r_cnt;
    int          n_vec = 0, n_err = 0;
    vec_t        sb[$];
    vec_t        tbl[35];

    always #5 clk = ~clk;

    clear_req_encoder #(.N(32), .RR_MODE(1'b0)) u_fix (
        .clk(clk), .rst_n(rst_n), .req_vec(f_req), .flush(f_flush), .ready(f_ready),
        .addr(f_addr), .clear_en(f_ce), .pend_cnt(f_cnt), .dup_hit(f_dup));

    clear_req_encoder #(.N(32), .RR_MODE(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n), .req_vec(r_req), .flush(r_flush), .ready(r_ready),
        .addr(r_addr), .clear_en(r_ce), .pend_cnt(r_cnt), .dup_hit(r_dup));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input bit rr, input logic ce, input logic [4:0] a,
                           input logic [5:0] c, input logic d);
        chk({tag, ".clear_en"}, rr ? r_ce : f_ce, ce);
        chk({tag, ".addr"}, rr ? r_addr : f_addr, a);
        chk({tag, ".pend_cnt"}, rr ? r_cnt : f_cnt, c);
        chk({tag, ".dup_hit"}, rr ? r_dup : f_dup, d);
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        f_req   = v.rr ? '0 : v.req;
        f_flush = v.rr ? 1'b0 : v.flush;
        f_ready = v.rr ? 1'b0 : v.ready;
        r_req   = v.rr ? v.req : '0;
        r_flush = v.rr ? v.flush : 1'b0;
        r_ready = v.rr ? v.ready : 1'b0;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk_out($sformatf("vec%0d", idx), e.rr, e.ce, e.addr, e.cnt, e.dup);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl = '{
            // fixed priority: reset release with all requests, then flush
            '{0, 32'hFFFF_FFFF, 0, 0, 1, 0, 32, 0},
            '{0, 32'h0, 1, 0, 0, 31, 0, 0},
            // drain 0, 4, 31
            '{0, 32'h8000_0011, 0, 1, 1, 0, 3, 0},
            '{0, 32'h0, 0, 1, 1, 4, 2, 0},
            '{0, 32'h0, 0, 1, 1, 31, 1, 0},
            '{0, 32'h0, 0, 1, 0, 31, 0, 0},
            // hold: bit 10 stays on addr while bit 2 arrives
            '{0, 32'h400, 0, 0, 1, 10, 1, 0},
            '{0, 32'h4, 0, 0, 1, 10, 2, 0},
            '{0, 32'h0, 0, 0, 1, 10, 2, 0},
            '{0, 32'h0, 0, 1, 1, 2, 1, 0},
            '{0, 32'h0, 0, 1, 0, 31, 0, 0},
            // duplicate on bit 7
            '{0, 32'h80, 0, 0, 1, 7, 1, 0},
            '{0, 32'h80, 0, 0, 1, 7, 1, 1},
            '{0, 32'h0, 0, 0, 1, 7, 1, 0},
            '{0, 32'h0, 0, 1, 0, 31, 0, 0},
            '{0, 32'h0, 0, 1, 0, 31, 0, 0},
            // flush mid-drain drops the same-cycle bit-0 request
            '{0, 32'hF000, 0, 0, 1, 12, 4, 0},
            '{0, 32'h0, 0, 1, 1, 13, 3, 0},
            '{0, 32'h1, 1, 1, 0, 31, 0, 0},
            '{0, 32'h0, 0, 1, 0, 31, 0, 0},
            // set wins over clear on the accepted bit
            '{0, 32'h8, 0, 1, 1, 3, 1, 0},
            '{0, 32'h8, 0, 1, 1, 3, 1, 0},
            '{0, 32'h0, 0, 1, 0, 31, 0, 0},
            // round robin: 1, 5, 30, 1 with re-request of bit 1
            '{1, 32'h4000_0022, 0, 1, 1, 1, 3, 0},
            '{1, 32'h2, 0, 1, 1, 5, 3, 0},
            '{1, 32'h0, 0, 1, 1, 30, 2, 0},
            '{1, 32'h0, 0, 1, 1, 1, 1, 0},
            '{1, 32'h0, 0, 1, 0, 31, 0, 0},
            // pointer at 2 picks 31 first, then wraps to 0
            '{1, 32'h8000_0001, 0, 1, 1, 31, 2, 0},
            '{1, 32'h0, 0, 1, 1, 0, 1, 0},
            '{1, 32'h0, 0, 1, 0, 31, 0, 0},
            // pointer at 1 skips bit 0; flush resets the pointer
            '{1, 32'h0010_0001, 0, 0, 1, 20, 2, 0},
            '{1, 32'h0, 1, 0, 0, 31, 0, 0},
            '{1, 32'h0010_0001, 0, 0, 1, 0, 2, 0},
            '{1, 32'h0, 1, 0, 0, 31, 0, 0}
        };
        #12;
        chk_out("in_reset", 0, 0, 31, 0, 0);
        chk_out("in_reset_rr", 1, 0, 31, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 35; i++) apply(tbl[i], i);
        // async reset mid-drain discards pending immediately
        apply('{0, 32'hF0, 0, 0, 1, 4, 4, 0}, 100);
        f_req = '0;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 31, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        apply('{0, 32'h0, 0, 1, 0, 31, 0, 0}, 101);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
